// File: rtl/fib_if.sv
// Control bundle between the Fibonacci sequencer and the regfile/ALU datapath.
// The sequencer takes the master side; the datapath (or the bench) takes the slave side.
interface fib_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [4:0]        n_terms;
    logic              alu_carry;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic [3:0]        alu_op;
    logic              imm_en;
    logic [DATA_W-1:0] imm_val;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [4:0]        term_count;

    modport master (
        input  start, n_terms, alu_carry,
        output rf_wen, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op, imm_en, imm_val,
               busy, done, ovf, term_count
    );

    modport slave (
        output start, n_terms, alu_carry,
        input  rf_wen, rf_waddr, rf_raddr_a, rf_raddr_b, alu_op, imm_en, imm_val,
               busy, done, ovf, term_count
    );
endinterface

// File: rtl/fib_sequencer.sv
// Fibonacci sequencer: writes term k into register k, one term per clock.
// Stops on the requested count or on ALU carry, then parks read port A on the last term.
module fib_sequencer #(
    parameter int         DATA_W = 16,
    parameter int         ADDR_W = 4,
    parameter logic [3:0] OP_ADD = 4'b0101,
    parameter logic [3:0] OP_MOV = 4'b1101
) (
    input logic   clk,
    input logic   rst,
    fib_if.master bus
);
    // state | meaning
    // IDLE  | waiting for start; read port A shows last written term
    // LOAD0 | write immediate 1 into r0
    // LOAD1 | write immediate 1 into r1
    // STEP  | r[idx] = r[idx-2] + r[idx-1]; abort without writing on carry
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, STEP, DONE} state_t;

    localparam logic [4:0] MAX_TERMS = 5'(2 ** ADDR_W);

    state_t            state;
    logic [4:0]        idx;
    logic [4:0]        target;
    logic [4:0]        term_count;
    logic [ADDR_W-1:0] last_idx;
    logic              ovf;

    logic              wr;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [3:0]        op;
    logic              imm_en;
    logic [DATA_W-1:0] imm_val;
    logic              busy;
    logic              done;
    logic [4:0]        n_clamped;

    assign n_clamped = (bus.n_terms > MAX_TERMS) ? MAX_TERMS : bus.n_terms;

    always_comb begin
        wr      = 1'b0;
        waddr   = '0;
        raddr_a = last_idx;
        raddr_b = '0;
        op      = OP_ADD;
        imm_en  = 1'b0;
        imm_val = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            LOAD0: begin
                wr      = 1'b1;
                op      = OP_MOV;
                imm_en  = 1'b1;
                imm_val = DATA_W'(1);
                busy    = 1'b1;
            end
            LOAD1: begin
                wr      = 1'b1;
                waddr   = ADDR_W'(1);
                op      = OP_MOV;
                imm_en  = 1'b1;
                imm_val = DATA_W'(1);
                busy    = 1'b1;
            end
            STEP: begin
                wr      = ~bus.alu_carry;
                waddr   = ADDR_W'(idx);
                raddr_a = ADDR_W'(idx - 5'd2);
                raddr_b = ADDR_W'(idx - 5'd1);
                busy    = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            target     <= '0;
            term_count <= '0;
            last_idx   <= '0;
            ovf        <= 1'b0;
        end else begin
            if (wr) begin
                term_count <= term_count + 5'd1;
                last_idx   <= waddr;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        target     <= n_clamped;
                        idx        <= '0;
                        ovf        <= 1'b0;
                        term_count <= '0;
                        state      <= (n_clamped == 5'd0) ? DONE : LOAD0;
                    end
                end
                LOAD0: state <= (target > 5'd1) ? LOAD1 : DONE;
                LOAD1: begin
                    if (target > 5'd2) begin
                        idx   <= 5'd2;
                        state <= STEP;
                    end else begin
                        state <= DONE;
                    end
                end
                STEP: begin
                    if (bus.alu_carry) begin
                        ovf   <= 1'b1;
                        state <= DONE;
                    end else if (idx == target - 5'd1) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // No regfile write may happen in a reset cycle, even mid-run.
    assign bus.rf_wen     = wr & ~rst;
    assign bus.rf_waddr   = waddr;
    assign bus.rf_raddr_a = raddr_a;
    assign bus.rf_raddr_b = raddr_b;
    assign bus.alu_op     = op;
    assign bus.imm_en     = imm_en;
    assign bus.imm_val    = imm_val;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.ovf        = ovf;
    assign bus.term_count = term_count;
endmodule
